// File: rtl/mux_select_unit_decoder.sv
// decoder_N: binary select to one-hot; out-of-range select decodes to all zeros
module decoder_N #(
  parameter int SIZE = 8,
  parameter int LOG_SIZE = $clog2(SIZE)
) (
  input  logic [LOG_SIZE-1:0] sel,
  output logic [SIZE-1:0]     dsel
);
  for (genvar k = 0; k < SIZE; k++) begin : g_dec
    assign dsel[k] = (sel == LOG_SIZE'(k));
  end
endmodule

// File: rtl/mux_select_unit_mux.sv
// mux_Nto1: encoded-select word mux; out-of-range select yields zero
module mux_Nto1 #(
  parameter int WIDTH = 4,
  parameter int SIZE = 8,
  parameter int LOG_SIZE = $clog2(SIZE)
) (
  input  logic [SIZE*WIDTH-1:0] in,
  input  logic [LOG_SIZE-1:0]   sel,
  output logic [WIDTH-1:0]      out
);
  always_comb begin
    out = '0;
    for (int k = 0; k < SIZE; k++)
      if (sel == LOG_SIZE'(k)) out = in[k*WIDTH +: WIDTH];
  end
endmodule

// File: rtl/mux_select_unit_mux_decoded.sv
// mux_Nto1_decoded: AND-OR word mux driven by a one-hot select (multi-hot ORs words)
module mux_Nto1_decoded #(
  parameter int WIDTH = 4,
  parameter int SIZE = 8
) (
  input  logic [SIZE*WIDTH-1:0] in,
  input  logic [SIZE-1:0]       dsel,
  output logic [WIDTH-1:0]      out
);
  always_comb begin
    out = '0;
    for (int k = 0; k < SIZE; k++)
      out = out | ({WIDTH{dsel[k]}} & in[k*WIDTH +: WIDTH]);
  end
endmodule

// File: rtl/mux_select_unit.sv
// mux_select_unit: registered word select through encoded and one-hot mux paths with cross-check
module mux_select_unit #(
  parameter int WIDTH = 4,
  parameter int SIZE = 8,
  parameter int LOG_SIZE = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SIZE*WIDTH-1:0] in,
  input  logic [LOG_SIZE-1:0]   sel,
  output logic [SIZE-1:0]       dsel,
  output logic [WIDTH-1:0]      out_enc,
  output logic [WIDTH-1:0]      out_dec,
  output logic                  mismatch
);
  logic [SIZE-1:0]  w_dsel, r_dsel;
  logic [WIDTH-1:0] w_enc, w_dec, r_enc, r_dec;
  logic             r_mismatch;
  decoder_N #(.SIZE(SIZE), .LOG_SIZE(LOG_SIZE)) u_dec (.sel(sel), .dsel(w_dsel));
  mux_Nto1 #(.WIDTH(WIDTH), .SIZE(SIZE), .LOG_SIZE(LOG_SIZE)) u_mux_enc (.in(in), .sel(sel), .out(w_enc));
  mux_Nto1_decoded #(.WIDTH(WIDTH), .SIZE(SIZE)) u_mux_dec (.in(in), .dsel(w_dsel), .out(w_dec));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dsel     <= '0;
      r_enc      <= '0;
      r_dec      <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_dsel     <= w_dsel;
      r_enc      <= w_enc;
      r_dec      <= w_dec;
      r_mismatch <= (w_enc != w_dec);
    end
  end
  assign dsel     = r_dsel;
  assign out_enc  = r_enc;
  assign out_dec  = r_dec;
  assign mismatch = r_mismatch;
endmodule

// File: tb/tb_mux_select_unit.sv
// tb_mux_select_unit: table-driven scoreboard bench for the 8-word build plus a 5-word build
module tb_mux_select_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_w = 32'h0;
  logic [2:0]  sel = 3'd0;
  logic [7:0]  dsel;
  logic [3:0]  out_enc, out_dec;
  logic        mismatch;
  logic [19:0] in5 = 20'h0;
  logic [2:0]  sel5 = 3'd0;
  logic [4:0]  dsel5;
  logic [3:0]  enc5, dec5;
  logic        mm5;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] in;
    logic [2:0]  sel;
    logic [3:0]  out;
    logic [7:0]  dsel;
  } vec_t;
  typedef struct {
    logic [3:0] out;
    logic [7:0] dsel;
  } exp_t;
  vec_t vecs[14];
  exp_t q[$];

  mux_select_unit #(.WIDTH(4), .SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_w), .sel(sel),
    .dsel(dsel), .out_enc(out_enc), .out_dec(out_dec), .mismatch(mismatch)
  );
  mux_select_unit #(.WIDTH(4), .SIZE(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in(in5), .sel(sel5),
    .dsel(dsel5), .out_enc(enc5), .out_dec(dec5), .mismatch(mm5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [3:0] eo, input logic [7:0] ed);
    chk({name, "_enc"}, 32'(out_enc), 32'(eo));
    chk({name, "_dec"}, 32'(out_dec), 32'(eo));
    chk({name, "_dsel"}, 32'(dsel), 32'(ed));
    chk({name, "_mm"}, 32'(mismatch), 32'h0);
  endtask

  task automatic step(input string name, input logic [31:0] i, input logic [2:0] s,
                      input logic [3:0] eo, input logic [7:0] ed);
    exp_t e;
    @(negedge clk);
    in_w = i;
    sel = s;
    q.push_back('{out: eo, dsel: ed});
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk({name, "_queue"}, 32'h0, 32'h1);
    end else begin
      e = q.pop_front();
      check_all(name, e.out, e.dsel);
    end
  endtask

  initial begin
    vecs[0]  = '{32'hABCDEF12, 3'd0, 4'h2, 8'h01};
    vecs[1]  = '{32'hABCDEF12, 3'd1, 4'h1, 8'h02};
    vecs[2]  = '{32'hABCDEF12, 3'd2, 4'hF, 8'h04};
    vecs[3]  = '{32'hABCDEF12, 3'd3, 4'hE, 8'h08};
    vecs[4]  = '{32'hABCDEF12, 3'd4, 4'hD, 8'h10};
    vecs[5]  = '{32'hABCDEF12, 3'd5, 4'hC, 8'h20};
    vecs[6]  = '{32'hABCDEF12, 3'd6, 4'hB, 8'h40};
    vecs[7]  = '{32'hABCDEF12, 3'd7, 4'hA, 8'h80};
    vecs[8]  = '{32'hABCDEF12, 3'd3, 4'hE, 8'h08};
    vecs[9]  = '{32'h0000F000, 3'd3, 4'hF, 8'h08};
    vecs[10] = '{32'h80000001, 3'd0, 4'h1, 8'h01};
    vecs[11] = '{32'h80000001, 3'd7, 4'h8, 8'h80};
    vecs[12] = '{32'h80000001, 3'd0, 4'h1, 8'h01};
    vecs[13] = '{32'h80000001, 3'd7, 4'h8, 8'h80};

    in_w = 32'hABCDEF12;
    sel = 3'd5;
    in5 = 20'h54321;
    sel5 = 3'd4;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 4'h0, 8'h00);
    chk("reset5_enc", 32'(enc5), 32'h0);
    chk("reset5_dsel", 32'(dsel5), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("release", 4'hC, 8'h20);
    chk("n5_sel4_enc", 32'(enc5), 32'h5);
    chk("n5_sel4_dec", 32'(dec5), 32'h5);
    chk("n5_sel4_dsel", 32'(dsel5), 32'h10);
    chk("n5_sel4_mm", 32'(mm5), 32'h0);

    for (int i = 0; i < 14; i++)
      step($sformatf("vec%0d", i), vecs[i].in, vecs[i].sel, vecs[i].out, vecs[i].dsel);

    step("pre_pulse", 32'hABCDEF12, 3'd6, 4'hB, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 4'h0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_pulse", 4'hB, 8'h40);

    @(negedge clk);
    sel5 = 3'd6;
    @(posedge clk);
    #1;
    chk("n5_sel6_enc", 32'(enc5), 32'h0);
    chk("n5_sel6_dec", 32'(dec5), 32'h0);
    chk("n5_sel6_dsel", 32'(dsel5), 32'h0);
    chk("n5_sel6_mm", 32'(mm5), 32'h0);
    @(negedge clk);
    sel5 = 3'd0;
    @(posedge clk);
    #1;
    chk("n5_sel0_enc", 32'(enc5), 32'h1);
    chk("n5_sel0_dsel", 32'(dsel5), 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
